// File: rtl/exec_pkg.sv
// Shared types for the RV32IM execute stage: ALU op codes, forward selects, divider states.
package exec_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [6:0] OPC_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic logic is_div_op(input alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic is_signed_div(input alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_rem_op(input alu_op_t op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle on operand magnitudes,
// sign fix-up on the way out. Result is held in DONE until the EX/MEM register takes it.
module seq_divider
  import exec_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          signed_op,
  input  logic          rem_op,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  input  logic          flush,
  input  logic          advance,
  output logic          busy_c,
  output logic [DW-1:0] result_c
);

  localparam int unsigned CW = $clog2(DW);

  div_state_t    state_q, state_d;
  logic          start;
  logic [DW-1:0] rem_q, quo_q, dsr_q;
  logic [CW-1:0] cnt_q;
  logic          rem_op_q, q_neg_q, r_neg_q;

  logic          a_neg, b_neg;
  logic [DW-1:0] a_mag, b_mag;
  logic [DW:0]   rem_sh;
  logic          fits;
  logic [DW-1:0] rem_nx, quo_nx;

  assign a_neg = signed_op & dividend[DW-1];
  assign b_neg = signed_op & divisor[DW-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  assign rem_sh = {rem_q, quo_q[DW-1]};
  assign fits   = rem_sh >= {1'b0, dsr_q};
  assign rem_nx = fits ? DW'(rem_sh - {1'b0, dsr_q}) : rem_sh[DW-1:0];
  assign quo_nx = {quo_q[DW-2:0], fits};

  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !flush && rst_n) begin
          state_d = DIV;
          busy_c  = 1'b1;
          start   = 1'b1;
        end
      end
      DIV: begin
        busy_c = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(DW - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (flush || advance) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      rem_op_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        rem_q    <= '0;
        quo_q    <= a_mag;
        dsr_q    <= b_mag;
        cnt_q    <= '0;
        rem_op_q <= rem_op;
        // A zero divisor must yield an all-ones quotient regardless of dividend sign.
        q_neg_q  <= (a_neg ^ b_neg) & (divisor != '0);
        r_neg_q  <= a_neg;
      end else if (state_q == DIV) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    result_c = '0;
    if (rem_op_q) begin
      result_c = r_neg_q ? -rem_q : rem_q;
    end else begin
      result_c = q_neg_q ? -quo_q : quo_q;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// RV32IM execute stage: operand forwarding, ALU with single-cycle multiply, branch resolution,
// iterative divider and the EX/MEM pipeline register.
module execute_stage
  import exec_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ROM_WIDTH  = 12,
  parameter int unsigned RF_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  regWriteE,
  input  logic [1:0]            resultSelE,
  input  logic                  memWriteE,
  input  logic [2:0]            memCtrlE,
  input  logic [6:0]            opE,
  input  logic [4:0]            aluCtrlE,
  input  logic                  aluSrcE,
  input  logic                  branchE,
  input  logic                  jumpE,
  input  logic [2:0]            funct3E,
  input  logic [DATA_WIDTH-1:0] rd1E,
  input  logic [DATA_WIDTH-1:0] rd2E,
  input  logic [1:0]            fwdAE,
  input  logic [1:0]            fwdBE,
  input  logic [DATA_WIDTH-1:0] regDin3W,
  input  logic [RF_WIDTH-1:0]   regAddr3E,
  input  logic [ROM_WIDTH-1:0]  pcE,
  input  logic [DATA_WIDTH-1:0] immExtE,
  input  logic                  stallM,
  input  logic                  flushM,
  output logic                  busyE,
  output logic                  pcSrcE,
  output logic [ROM_WIDTH-1:0]  pcTargetE,
  output logic                  regWriteM,
  output logic [1:0]            resultSelM,
  output logic                  memWriteM,
  output logic [2:0]            memCtrlM,
  output logic [6:0]            opM,
  output logic [RF_WIDTH-1:0]   regAddr3M,
  output logic [ROM_WIDTH-1:0]  pcM,
  output logic [DATA_WIDTH-1:0] immExtM,
  output logic [DATA_WIDTH-1:0] aluResultM,
  output logic [DATA_WIDTH-1:0] memDinM
);

  localparam int unsigned DW  = DATA_WIDTH;
  localparam int unsigned RMW = ROM_WIDTH;
  localparam int unsigned SHW = $clog2(DATA_WIDTH);

  alu_op_t        alu_op;
  logic [DW-1:0]  src_a, fwd_b, src_b;
  logic [DW-1:0]  alu_result, div_result;
  logic [SHW-1:0] shamt;

  assign alu_op = alu_op_t'(aluCtrlE);

  always_comb begin
    src_a = rd1E;
    fwd_b = rd2E;
    case (fwdAE)
      FWD_WB:  src_a = regDin3W;
      FWD_MEM: src_a = aluResultM;
      default: src_a = rd1E;
    endcase
    case (fwdBE)
      FWD_WB:  fwd_b = regDin3W;
      FWD_MEM: fwd_b = aluResultM;
      default: fwd_b = rd2E;
    endcase
  end

  assign src_b = aluSrcE ? immExtE : fwd_b;
  assign shamt = src_b[SHW-1:0];

  // One 2*DW multiplier; per-operand sign extension selects MULH/MULHSU/MULHU.
  logic            mul_a_signed, mul_b_signed;
  logic [2*DW-1:0] mul_a, mul_b, mul_prod;

  assign mul_a_signed = (alu_op == ALU_MULH) || (alu_op == ALU_MULHSU);
  assign mul_b_signed = (alu_op == ALU_MULH);
  assign mul_a        = {{DW{mul_a_signed & src_a[DW-1]}}, src_a};
  assign mul_b        = {{DW{mul_b_signed & src_b[DW-1]}}, src_b};
  assign mul_prod     = mul_a * mul_b;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD:    alu_result = src_a + src_b;
      ALU_SUB:    alu_result = src_a - src_b;
      ALU_SLL:    alu_result = src_a << shamt;
      ALU_SLT:    alu_result = DW'($signed(src_a) < $signed(src_b));
      ALU_SLTU:   alu_result = DW'(src_a < src_b);
      ALU_XOR:    alu_result = src_a ^ src_b;
      ALU_SRL:    alu_result = src_a >> shamt;
      ALU_SRA:    alu_result = DW'($signed(src_a) >>> shamt);
      ALU_OR:     alu_result = src_a | src_b;
      ALU_AND:    alu_result = src_a & src_b;
      ALU_MUL:    alu_result = mul_prod[DW-1:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  alu_result = mul_prod[2*DW-1:DW];
      ALU_DIV,
      ALU_DIVU,
      ALU_REM,
      ALU_REMU:   alu_result = div_result;
      default:    alu_result = '0;
    endcase
  end

  seq_divider #(
    .DW(DW)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (is_div_op(alu_op)),
    .signed_op (is_signed_div(alu_op)),
    .rem_op    (is_rem_op(alu_op)),
    .dividend  (src_a),
    .divisor   (src_b),
    .flush     (flushM),
    .advance   (!stallM),
    .busy_c    (busyE),
    .result_c  (div_result)
  );

  // Branch condition compares the forwarded register operands, never the immediate.
  logic branch_cond;
  always_comb begin
    branch_cond = 1'b0;
    case (funct3E)
      3'b000:  branch_cond = src_a == fwd_b;
      3'b001:  branch_cond = src_a != fwd_b;
      3'b100:  branch_cond = $signed(src_a) < $signed(fwd_b);
      3'b101:  branch_cond = $signed(src_a) >= $signed(fwd_b);
      3'b110:  branch_cond = src_a < fwd_b;
      3'b111:  branch_cond = src_a >= fwd_b;
      default: branch_cond = 1'b0;
    endcase
  end

  logic [RMW-1:0] jalr_target;
  assign jalr_target = (RMW'(src_a) + RMW'(immExtE)) & ~RMW'(1);
  assign pcTargetE   = (jumpE && (opE == OPC_JALR)) ? jalr_target : pcE + RMW'(immExtE);
  assign pcSrcE      = !busyE && (jumpE || (branchE && branch_cond));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regWriteM  <= 1'b0;
      resultSelM <= '0;
      memWriteM  <= 1'b0;
      memCtrlM   <= '0;
      opM        <= '0;
      regAddr3M  <= '0;
      pcM        <= '0;
      immExtM    <= '0;
      aluResultM <= '0;
      memDinM    <= '0;
    end else if (flushM) begin
      regWriteM <= 1'b0;
      memWriteM <= 1'b0;
    end else if (stallM) begin
      regWriteM <= regWriteM;
    end else if (busyE) begin
      regWriteM <= 1'b0;
      memWriteM <= 1'b0;
    end else begin
      regWriteM  <= regWriteE;
      resultSelM <= resultSelE;
      memWriteM  <= memWriteE;
      memCtrlM   <= memCtrlE;
      opM        <= opE;
      regAddr3M  <= regAddr3E;
      pcM        <= pcE;
      immExtM    <= immExtE;
      aluResultM <= alu_result;
      memDinM    <= fwd_b;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed corner cases plus randomized ALU/divide traffic
// compared against an arithmetic reference model.
module tb_execute_stage;
  import exec_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        regWriteE;
  logic [1:0]  resultSelE;
  logic        memWriteE;
  logic [2:0]  memCtrlE;
  logic [6:0]  opE;
  logic [4:0]  aluCtrlE;
  logic        aluSrcE, branchE, jumpE;
  logic [2:0]  funct3E;
  logic [31:0] rd1E, rd2E, regDin3W, immExtE;
  logic [1:0]  fwdAE, fwdBE;
  logic [4:0]  regAddr3E;
  logic [11:0] pcE;
  logic        stallM, flushM;
  logic        busyE, pcSrcE;
  logic [11:0] pcTargetE;
  logic        regWriteM, memWriteM;
  logic [1:0]  resultSelM;
  logic [2:0]  memCtrlM;
  logic [6:0]  opM;
  logic [4:0]  regAddr3M;
  logic [11:0] pcM;
  logic [31:0] immExtM, aluResultM, memDinM;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_res;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .regWriteE(regWriteE), .resultSelE(resultSelE),
    .memWriteE(memWriteE), .memCtrlE(memCtrlE), .opE(opE), .aluCtrlE(aluCtrlE),
    .aluSrcE(aluSrcE), .branchE(branchE), .jumpE(jumpE), .funct3E(funct3E),
    .rd1E(rd1E), .rd2E(rd2E), .fwdAE(fwdAE), .fwdBE(fwdBE), .regDin3W(regDin3W),
    .regAddr3E(regAddr3E), .pcE(pcE), .immExtE(immExtE), .stallM(stallM), .flushM(flushM),
    .busyE(busyE), .pcSrcE(pcSrcE), .pcTargetE(pcTargetE), .regWriteM(regWriteM),
    .resultSelM(resultSelM), .memWriteM(memWriteM), .memCtrlM(memCtrlM), .opM(opM),
    .regAddr3M(regAddr3M), .pcM(pcM), .immExtM(immExtM), .aluResultM(aluResultM),
    .memDinM(memDinM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: RV32IM semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int          sa, sb;
    int unsigned sh;
    longint      pl;
    logic [63:0] pu;
    sa = a;
    sb = b;
    sh = b % 32;
    case (op)
      ALU_ADD:    return a + b;
      ALU_SUB:    return a - b;
      ALU_SLL:    return a << sh;
      ALU_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU:   return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:    return a ^ b;
      ALU_SRL:    return a >> sh;
      ALU_SRA:    return 32'(sa >>> sh);
      ALU_OR:     return a | b;
      ALU_AND:    return a & b;
      ALU_MUL:    begin pl = longint'(sa) * longint'(sb); return pl[31:0]; end
      ALU_MULH:   begin pl = longint'(sa) * longint'(sb); return pl[63:32]; end
      ALU_MULHSU: begin pl = longint'(sa) * longint'({32'd0, b}); return pl[63:32]; end
      ALU_MULHU:  begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      ALU_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      ALU_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      ALU_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      ALU_REMU:   return (b == 32'd0) ? a : a % b;
      default:    return 32'd0;
    endcase
  endfunction

  function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return sa < sb;
      3'b101:  return sa >= sb;
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] fwd_val(input logic [1:0] sel, input logic [31:0] rd);
    case (sel)
      2'b01:   return regDin3W;
      2'b10:   return m_res;
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 4))
      0:       return 32'($urandom_range(0, 8));
      1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 8));
      2:       return 32'h8000_0000 ^ 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  task automatic idle_inputs();
    regWriteE = 1'b0; resultSelE = 2'd0; memWriteE = 1'b0; memCtrlE = 3'd0; opE = 7'd0;
    aluCtrlE = ALU_ADD; aluSrcE = 1'b0; branchE = 1'b0; jumpE = 1'b0; funct3E = 3'd0;
    rd1E = 32'd0; rd2E = 32'd0; fwdAE = 2'd0; fwdBE = 2'd0; regDin3W = 32'd0;
    regAddr3E = 5'd0; pcE = 12'd0; immExtE = 32'd0; stallM = 1'b0; flushM = 1'b0;
  endtask

  // Called right after driving E inputs: checks redirect, then the captured EX/MEM contents.
  task automatic step_check(input string tag);
    logic [31:0] a, fb, b, exp;
    logic        taken;
    logic [11:0] tgt;
    a     = fwd_val(fwdAE, rd1E);
    fb    = fwd_val(fwdBE, rd2E);
    b     = aluSrcE ? immExtE : fb;
    exp   = ref_alu(aluCtrlE, a, b);
    taken = jumpE | (branchE & ref_cond(funct3E, a, fb));
    if (jumpE && opE == 7'b1100111) tgt = 12'(a + immExtE) & 12'hFFE;
    else                            tgt = pcE + 12'(immExtE);
    #1;
    check({tag, "/pcsrc"}, 32'(pcSrcE), 32'(taken));
    check({tag, "/pctgt"}, 32'(pcTargetE), 32'(tgt));
    @(posedge clk); #1;
    check({tag, "/alu"}, aluResultM, exp);
    check({tag, "/din"}, memDinM, fb);
    check({tag, "/ctl"}, 32'({regWriteM, memWriteM, resultSelM, memCtrlM, opM}),
          32'({regWriteE, memWriteE, resultSelE, memCtrlE, opE}));
    check({tag, "/addr"}, 32'({regAddr3M, pcM}), 32'({regAddr3E, pcE}));
    check({tag, "/imm"}, immExtM, immExtE);
    m_res = exp;
  endtask

  task automatic run_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
    int cnt;
    idle_inputs();
    aluCtrlE = op; rd1E = a; rd2E = b; regWriteE = 1'b1;
    #1;
    check({tag, "/busy_start"}, 32'(busyE), 32'd1);
    cnt = 0;
    while (busyE === 1'b1 && cnt < 40) begin
      cnt++;
      @(posedge clk); #1;
    end
    check({tag, "/busy_cycles"}, 32'(cnt), 32'd33);
    check({tag, "/bubble"}, 32'(regWriteM), 32'd0);
    @(posedge clk); #1;
    check({tag, "/result"}, aluResultM, exp);
    check({tag, "/wr"}, 32'(regWriteM), 32'd1);
    m_res = exp;
    idle_inputs();
  endtask

  logic [2:0] f3s [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    int          cnt;
    m_res = 32'd0;
    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("reset/busy", 32'(busyE), 32'd0);
    check("reset/alu", aluResultM, 32'd0);
    check("reset/ctl", 32'({regWriteM, memWriteM, pcM}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD wraps to the most negative value.
    idle_inputs();
    aluCtrlE = ALU_ADD; rd1E = 32'h7FFF_FFFF; immExtE = 32'd1; aluSrcE = 1'b1; regWriteE = 1'b1;
    step_check("add_ovf");
    check("add_ovf/const", aluResultM, 32'h8000_0000);

    // Forward from M wins over rd1E.
    idle_inputs();
    aluCtrlE = ALU_ADD; rd1E = 32'd2; rd2E = 32'd3; regWriteE = 1'b1;
    step_check("fwd_setup");
    aluCtrlE = ALU_SUB; fwdAE = 2'b10; rd1E = 32'd9; rd2E = 32'd2;
    step_check("fwd_sub");
    check("fwd_sub/const", aluResultM, 32'd3);

    for (int i = 0; i < 150; i++) begin
      aluCtrlE   = 5'($urandom_range(0, 13));
      rd1E       = rnd();
      rd2E       = rnd();
      immExtE    = rnd();
      regDin3W   = $urandom;
      fwdAE      = 2'($urandom_range(0, 2));
      fwdBE      = 2'($urandom_range(0, 2));
      aluSrcE    = 1'($urandom);
      regWriteE  = 1'($urandom);
      memWriteE  = 1'($urandom);
      resultSelE = 2'($urandom);
      memCtrlE   = 3'($urandom);
      regAddr3E  = 5'($urandom);
      pcE        = 12'($urandom);
      branchE    = 1'($urandom);
      jumpE      = ($urandom_range(0, 3) == 0);
      funct3E    = f3s[$urandom_range(0, 5)];
      opE        = ($urandom_range(0, 1) == 1) ? 7'b1100111 : 7'($urandom);
      step_check($sformatf("rand%0d", i));
    end

    run_div(ALU_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, "div_m7_2");
    run_div(ALU_REM,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, "rem_m7_2");
    run_div(ALU_DIVU, 32'h1234_5678, 32'd0,        32'hFFFF_FFFF, "divu_by0");
    run_div(ALU_DIV,  32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFFF, "div_neg_by0");
    run_div(ALU_REM,  32'hFFFF_FFF0, 32'd0,        32'hFFFF_FFF0, "rem_by0");
    run_div(ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        "rem_ovf");
    run_div(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    run_div(ALU_REMU, 32'hFFFF_FFFF, 32'd10,        32'd5,        "remu");
    for (int i = 0; i < 10; i++) begin
      op = 5'($urandom_range(14, 17));
      a  = rnd();
      b  = rnd();
      run_div(op, a, b, ref_alu(op, a, b), $sformatf("rdiv%0d", i));
    end

    // Stall in DONE: FSM must hold the result and not restart; redirect masked while busy.
    idle_inputs();
    aluCtrlE = ALU_DIV; rd1E = 32'd100; rd2E = 32'd7; regWriteE = 1'b1; jumpE = 1'b1;
    #1;
    check("stall/pcsrc_masked", 32'(pcSrcE), 32'd0);
    jumpE = 1'b0;
    cnt = 0;
    while (busyE === 1'b1 && cnt < 40) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("stall/busy_cycles", 32'(cnt), 32'd33);
    stallM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall/busy_low", 32'(busyE), 32'd0);
      check("stall/bubble_held", 32'(regWriteM), 32'd0);
    end
    stallM = 1'b0;
    @(posedge clk); #1;
    check("stall/result", aluResultM, 32'd14);
    check("stall/wr", 32'(regWriteM), 32'd1);
    m_res = 32'd14;
    idle_inputs();

    // Flush mid-divide aborts; control bits cleared.
    aluCtrlE = ALU_DIVU; rd1E = 32'd1000; rd2E = 32'd3; regWriteE = 1'b1;
    #1;
    repeat (5) @(posedge clk);
    #1;
    flushM = 1'b1; memWriteE = 1'b1;
    #1;
    check("flush/busy_same_cycle", 32'(busyE), 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    #1;
    check("flush/busy_drop", 32'(busyE), 32'd0);
    check("flush/ctl", 32'({regWriteM, memWriteM}), 32'd0);
    aluCtrlE = ALU_OR; rd1E = 32'h00F0; rd2E = 32'h0F00; regWriteE = 1'b1;
    step_check("after_flush");

    // Flush beats stall; then a plain stall holds the register.
    idle_inputs();
    aluCtrlE = ALU_ADD; rd1E = 32'd1; rd2E = 32'd1; regWriteE = 1'b1; memWriteE = 1'b1;
    stallM = 1'b1; flushM = 1'b1;
    @(posedge clk); #1;
    check("flush_prio/ctl", 32'({regWriteM, memWriteM}), 32'd0);
    idle_inputs();
    aluCtrlE = ALU_XOR; rd1E = 32'hA5A5_0000; rd2E = 32'h0000_5A5A; regWriteE = 1'b1;
    step_check("pre_stall");
    aluCtrlE = ALU_SUB; rd1E = 32'd50; regWriteE = 1'b0; stallM = 1'b1;
    @(posedge clk); #1;
    check("stall_hold/alu", aluResultM, m_res);
    check("stall_hold/wr", 32'(regWriteM), 32'd1);
    idle_inputs();

    // Reset mid-divide.
    aluCtrlE = ALU_DIV; rd1E = 32'd12345; rd2E = 32'd17; regWriteE = 1'b1;
    #1;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid/busy", 32'(busyE), 32'd0);
    check("rst_mid/alu", aluResultM, 32'd0);
    check("rst_mid/ctl", 32'({regWriteM, memWriteM, pcM}), 32'd0);
    check("rst_mid/din", memDinM, 32'd0);
    @(posedge clk); #1;
    check("rst_hold/busy", 32'(busyE), 32'd0);
    idle_inputs();
    rst_n = 1'b1;
    m_res = 32'd0;
    @(posedge clk); #1;
    run_div(ALU_DIV, 32'd12345, 32'd17, 32'd726, "div_after_rst");

    // Branch comparisons: signed vs unsigned, and JALR target alignment.
    idle_inputs();
    branchE = 1'b1; funct3E = 3'b100; rd1E = 32'hFFFF_FFFF; rd2E = 32'd0;
    pcE = 12'h100; immExtE = 32'h20; aluSrcE = 1'b1;
    #1;
    check("blt/pcsrc", 32'(pcSrcE), 32'd1);
    check("blt/target", 32'(pcTargetE), 32'h120);
    step_check("blt");
    funct3E = 3'b110;
    #1;
    check("bltu/pcsrc", 32'(pcSrcE), 32'd0);
    step_check("bltu");
    idle_inputs();
    jumpE = 1'b1; opE = 7'b1100111; rd1E = 32'h203; immExtE = 32'h10; aluSrcE = 1'b1;
    #1;
    check("jalr/pcsrc", 32'(pcSrcE), 32'd1);
    check("jalr/target", 32'(pcTargetE), 32'h212);
    step_check("jalr");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
